// File: rtl/ser_rx_deser_pkg.sv
// Shared constants for the single-wire serial link: word width, bit order,
// and the counter-width helper used by both ends of the link.
package ser_pkg;

    localparam int SER_W = 8;

    // Both the serializer and the receiver treat the first bit on the wire as bit 0.
    localparam bit SER_LSB_FIRST = 1'b1;

    function automatic int cnt_w(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/ser_rx_deser_shift_in.sv
// W-bit right-shifting input register: each enabled edge drops the new bit
// into the MSB, so after W shifts the first bit received sits at bit 0.
module ser_shift_in
    import ser_pkg::*;
#(
    parameter int W = SER_W
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         clr,
    input  logic         en,
    input  logic         b_in,
    output logic [W-1:0] sr
);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            sr <= '0;
        end else if (clr) begin
            sr <= '0;
        end else if (en) begin
            sr <= {b_in, sr[W-1:1]};
        end
    end

endmodule

// File: rtl/ser_rx_deser.sv
// Serial-to-parallel receiver: assembles W-bit LSB-first words from strobed
// bits and hands them out through a one-deep holding register.
module ser_rx_deser
    import ser_pkg::*;
#(
    parameter int W = SER_W
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic                  sh_in,
    input  logic                  b_in,
    input  logic                  clr,
    input  logic                  rdy,
    output logic [W-1:0]          data_out,
    output logic                  valid,
    output logic                  busy,
    output logic                  ovr,
    output logic [cnt_w(W)-1:0]   bit_cnt
);

    localparam int                CNT_W = cnt_w(W);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(W - 1);

    logic [W-1:0] sr;
    logic [W-1:0] cw;
    logic         complete;

    ser_shift_in #(.W(W)) u_shift_in (
        .clk   (clk),
        .rst_b (rst_b),
        .clr   (clr),
        .en    (sh_in),
        .b_in  (b_in),
        .sr    (sr)
    );

    assign cw       = {b_in, sr[W-1:1]};
    assign complete = sh_in && (bit_cnt == LAST);
    assign busy     = (bit_cnt != '0);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            bit_cnt <= '0;
        end else if (clr) begin
            bit_cnt <= '0;
        end else if (sh_in) begin
            bit_cnt <= complete ? '0 : bit_cnt + 1'b1;
        end
    end

    // Handshake: a word transfers on any edge with valid=1 and rdy=1. A
    // completion on that same edge refills the register so valid stays high;
    // a completion while valid=1 and rdy=0 drops the new word and sets ovr.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            data_out <= '0;
            valid    <= 1'b0;
            ovr      <= 1'b0;
        end else if (clr) begin
            data_out <= '0;
            valid    <= 1'b0;
            ovr      <= 1'b0;
        end else if (complete) begin
            if (!valid || rdy) begin
                data_out <= cw;
                valid    <= 1'b1;
            end else begin
                ovr <= 1'b1;
            end
        end else if (valid && rdy) begin
            valid <= 1'b0;
        end
    end

endmodule
